imem_port_arbiter: RTL and testbench
====================================

// Module: imem_port_arbiter
// PURPOSE
//  Shares the single 8 KiB (2048-word) instruction memory between two requesters:
//  - Port F: core instruction fetch (read-only).
//  - Port L: program loader/debug (read/write).
//  Block sits between both requesters and a synchronous single-port word RAM.
//  It provides fixed L>F priority with a starvation guard, 1-cycle read latency,
//  and error/NOP handling for misaligned and out-of-range addresses.
// PARAMETERS
//  MEM_WORDS  2048         words in instruction memory; valid byte addr < MEM_WORDS*4
//  MAX_WAIT   4            max consecutive L grants while F waits before F is forced
//  NOP_WORD   32'h00000013 data returned to F on out-of-range fetch
// PORTS
//  i_clk          in   1   clock, rising edge
//  i_reset        in   1   asynchronous, active-high reset
//  i_f_valid      in   1   fetch request valid
//  i_f_addr       in   32  fetch byte address
//  o_f_ready      out  1   fetch request accepted this cycle
//  o_f_rvalid     out  1   fetch response valid (1 cycle after accept)
//  o_f_rdata      out  32  fetch response data
//  o_f_err        out  1   fetch response error (misaligned), qualified by o_f_rvalid
//  i_l_valid      in   1   loader request valid
//  i_l_we         in   1   loader write enable
//  i_l_addr       in   32  loader byte address
//  i_l_wdata      in   32  loader write data
//  o_l_ready      out  1   loader request accepted this cycle
//  o_l_rvalid     out  1   loader response valid (reads and writes both respond)
//  o_l_rdata      out  32  loader read data (0 for writes and errors)
//  o_l_err        out  1   loader error (misaligned or out of range)
//  o_mem_en       out  1   RAM access strobe
//  o_mem_we       out  1   RAM write strobe
//  o_mem_idx      out  11  RAM word index = addr[12:2]
//  o_mem_wdata    out  32  RAM write data
//  i_mem_rdata    in   32  RAM read data, valid cycle after o_mem_en
//  o_stat_f_stall out  16  see CONFIGURATION
//  o_stat_l_grant out  16  see CONFIGURATION
// BEHAVIOUR
//  - Reset: all outputs 0; wait counter 0; in-flight tag cleared. Reset mid-access
//    drops the pending response; no rvalid after reset deasserts.
//  - Handshake: request accepted when valid && ready.
//    - At most one grant per cycle; ready is combinational on valid and arbiter state.
//    - Requester must hold addr/data stable while valid && !ready.
//  - Arbitration:
//    - Only L valid: grant L. Only F valid: grant F.
//    - Both valid: grant L unless wait_cnt==MAX_WAIT, in which case grant F.
//    - wait_cnt increments on each L grant while F is valid and not granted.
//    - wait_cnt clears on any F grant or any cycle with F not valid; saturates at MAX_WAIT.
//  - Throughput: one access per cycle, back-to-back allowed.
//    - Grant cycle N drives o_mem_*.
//    - Response in cycle N+1: rvalid=1 for exactly one cycle; rdata = i_mem_rdata.
//    - A registered port tag routes the response to the granting port.
//  - Error checks, evaluated at grant:
//    - Misaligned: addr[1:0]!=0 -> o_mem_en=0; N+1 rvalid=1, err=1, rdata=0.
//    - Out of range: addr >= MEM_WORDS*4.
//      - F: o_mem_en=0; N+1 rdata=NOP_WORD, err=0.
//      - L: o_mem_en=0; N+1 rdata=0, err=1 (write suppressed).
//    - Misaligned takes precedence over out of range.
//  - Writes (L only): o_mem_we=1 with o_mem_en in cycle N; rvalid N+1 with rdata=0.
//    - An F read of the same word in N+1 sees the new data.
//  - o_mem_idx/o_mem_wdata hold last value when o_mem_en=0; o_mem_we=0 whenever o_mem_en=0.
// CONFIGURATION
//  IMEM_ARB_STATS_EN defined:
//  - o_stat_f_stall counts cycles with i_f_valid && !o_f_ready.
//  - o_stat_l_grant counts L grants.
//  - Both are 16-bit, saturating at 16'hFFFF, and cleared by reset.
//  Not defined: both outputs tied to 0; no counter flops.
// TESTING
//  - Reset then F read addr 0x0 with RAM[0]=0xDEADBEEF -> o_f_ready same cycle;
//    next cycle o_f_rvalid=1, o_f_rdata=0xDEADBEEF, err=0.
//  - L write 0x10 data 0x12345678, then F read 0x10 in next cycle -> F rdata 0x12345678.
//  - F and L both valid for 10 cycles, MAX_WAIT=4 -> grants L,L,L,L,F,L,L,L,L,F.
//  - F read 0x2002 -> err=1, no o_mem_en. F read 0x2000 -> rdata 0x00000013, err=0.
//  - L write 0x4000 -> o_l_err=1, o_mem_we never asserted.
//  - Assert i_reset in the grant cycle of an L read -> no o_l_rvalid afterwards.
//  - With IMEM_ARB_STATS_EN defined -> stat counts match.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one single-port instruction RAM between fetch (F) and loader (L)
// Define IMEM_ARB_STATS_EN to build the saturating stall/grant statistics counters.
module imem_port_arbiter #(
  parameter int          MEM_WORDS = 2048,
  parameter int          MAX_WAIT  = 4,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_f_valid,
  input  logic [31:0] i_f_addr,
  output logic        o_f_ready,
  output logic        o_f_rvalid,
  output logic [31:0] o_f_rdata,
  output logic        o_f_err,
  input  logic        i_l_valid,
  input  logic        i_l_we,
  input  logic [31:0] i_l_addr,
  input  logic [31:0] i_l_wdata,
  output logic        o_l_ready,
  output logic        o_l_rvalid,
  output logic [31:0] o_l_rdata,
  output logic        o_l_err,
  output logic        o_mem_en,
  output logic        o_mem_we,
  output logic [10:0] o_mem_idx,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  output logic [15:0] o_stat_f_stall,
  output logic [15:0] o_stat_l_grant
);
  localparam logic [31:0] LIMIT = 32'(MEM_WORDS * 4);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);
  localparam logic [1:0] SRC_ZERO = 2'd0;
  localparam logic [1:0] SRC_MEM  = 2'd1;
  localparam logic [1:0] SRC_NOP  = 2'd2;
  logic [WW-1:0] wait_q, wait_d;
  logic [10:0] idx_q;
  logic [31:0] wdata_q, addr, rdata;
  logic [1:0] src_q, src_d;
  logic f_rsp_q, l_rsp_q, err_q, err_d;
  logic gnt_l, gnt_f, gnt, mis, oor;
  // Grants are masked during reset so every output reads 0 while it is held.
  always_comb begin
    gnt_l       = !i_reset && i_l_valid && !(i_f_valid && wait_q == WMAX);
    gnt_f       = !i_reset && i_f_valid && !gnt_l;
    gnt         = gnt_l || gnt_f;
    addr        = gnt_l ? i_l_addr : i_f_addr;
    mis         = addr[1:0] != 2'b00;
    oor         = addr >= LIMIT;
    o_f_ready   = gnt_f;
    o_l_ready   = gnt_l;
    o_mem_en    = gnt && !mis && !oor;
    o_mem_we    = o_mem_en && gnt_l && i_l_we;
    o_mem_idx   = o_mem_en ? addr[12:2] : idx_q;
    o_mem_wdata = o_mem_we ? i_l_wdata : wdata_q;
    err_d       = mis || (oor && gnt_l);
    src_d       = mis ? SRC_ZERO : oor ? (gnt_l ? SRC_ZERO : SRC_NOP) : (gnt_l && i_l_we) ? SRC_ZERO : SRC_MEM;
    wait_d      = (!i_f_valid || gnt_f) ? '0 : (gnt_l && wait_q != WMAX) ? wait_q + 1'b1 : wait_q;
    rdata       = src_q == SRC_MEM ? i_mem_rdata : src_q == SRC_NOP ? NOP_WORD : '0;
    o_f_rvalid  = f_rsp_q;
    o_f_rdata   = f_rsp_q ? rdata : '0;
    o_f_err     = f_rsp_q && err_q;
    o_l_rvalid  = l_rsp_q;
    o_l_rdata   = l_rsp_q ? rdata : '0;
    o_l_err     = l_rsp_q && err_q;
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wait_q  <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      src_q   <= SRC_ZERO;
      err_q   <= 1'b0;
      f_rsp_q <= 1'b0;
      l_rsp_q <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      idx_q   <= o_mem_idx;
      wdata_q <= o_mem_wdata;
      src_q   <= src_d;
      err_q   <= err_d;
      f_rsp_q <= gnt_f;
      l_rsp_q <= gnt_l;
    end
  end
`ifdef IMEM_ARB_STATS_EN
  logic [15:0] f_stall_q, l_grant_q;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      f_stall_q <= '0;
      l_grant_q <= '0;
    end else begin
      if (i_f_valid && !gnt_f && f_stall_q != 16'hFFFF) f_stall_q <= f_stall_q + 16'd1;
      if (gnt_l && l_grant_q != 16'hFFFF) l_grant_q <= l_grant_q + 16'd1;
    end
  end
  assign o_stat_f_stall = f_stall_q;
  assign o_stat_l_grant = l_grant_q;
`else
  assign o_stat_f_stall = '0;
  assign o_stat_l_grant = '0;
`endif
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: randomized self-checking bench with a word-level memory reference model
module tb_imem_port_arbiter;
  localparam int MAXW = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        i_clk = 1'b0, i_reset = 1'b0;
  logic        i_f_valid = 1'b0, i_l_valid = 1'b0, i_l_we = 1'b0;
  logic [31:0] i_f_addr = '0, i_l_addr = '0, i_l_wdata = '0, i_mem_rdata = '0;
  logic        o_f_ready, o_f_rvalid, o_f_err, o_l_ready, o_l_rvalid, o_l_err, o_mem_en, o_mem_we;
  logic [31:0] o_f_rdata, o_l_rdata, o_mem_wdata;
  logic [10:0] o_mem_idx;
  logic [15:0] o_stat_f_stall, o_stat_l_grant;
  logic [31:0] ram [2048];
  logic [31:0] exp_mem [2048];
  logic        bd_we = 1'b0;
  logic [10:0] bd_idx = '0;
  logic [31:0] bd_data = '0;
  int n_cmp = 0, n_fail = 0, n_stall = 0, n_lgnt = 0;
  logic        obs_f_ready, obs_l_ready, obs_mem_en, obs_mem_we, obs_f_rvalid, obs_f_err, obs_l_rvalid, obs_l_err;
  logic [31:0] obs_f_rdata, obs_l_rdata, obs_mem_wdata;
  logic [10:0] obs_mem_idx;
  logic [15:0] obs_stat_f, obs_stat_l;

  imem_port_arbiter dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_f_valid(i_f_valid), .i_f_addr(i_f_addr), .o_f_ready(o_f_ready),
    .o_f_rvalid(o_f_rvalid), .o_f_rdata(o_f_rdata), .o_f_err(o_f_err),
    .i_l_valid(i_l_valid), .i_l_we(i_l_we), .i_l_addr(i_l_addr), .i_l_wdata(i_l_wdata),
    .o_l_ready(o_l_ready), .o_l_rvalid(o_l_rvalid), .o_l_rdata(o_l_rdata), .o_l_err(o_l_err),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_idx(o_mem_idx), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .o_stat_f_stall(o_stat_f_stall), .o_stat_l_grant(o_stat_l_grant)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (bd_we) ram[bd_idx] <= bd_data;
    else if (o_mem_en) begin
      if (o_mem_we) ram[o_mem_idx] <= o_mem_wdata;
      i_mem_rdata <= ram[o_mem_idx];
    end
  end

  // Reference: what one accepted request must return, following the port rules at word level.
  function automatic void model_access(input logic is_l, input logic we, input logic [31:0] a,
                                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
    if (a % 4 != 0) begin rd = '0; er = 1'b1; end
    else if (a >= 32'd8192) begin rd = is_l ? 32'd0 : NOP; er = is_l; end
    else if (is_l && we) begin exp_mem[a / 4] = wd; rd = '0; er = 1'b0; end
    else begin rd = exp_mem[a / 4]; er = 1'b0; end
  endfunction

  function automatic logic [31:0] rand_addr();
    int r = int'($urandom_range(0, 9));
    if (r == 0) return 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
    if (r == 1) return 32'(32'h2000 + $urandom_range(0, 1023) * 4);
    return 32'($urandom_range(0, 15) * 4);
  endfunction

  task automatic step(input logic fv, input logic [31:0] fa, input logic lv, input logic lwe,
                      input logic [31:0] la, input logic [31:0] ld);
    i_f_valid = fv; i_f_addr = fa; i_l_valid = lv; i_l_we = lwe; i_l_addr = la; i_l_wdata = ld;
    @(negedge i_clk);
    obs_f_ready = o_f_ready; obs_l_ready = o_l_ready; obs_mem_en = o_mem_en; obs_mem_we = o_mem_we;
    obs_mem_idx = o_mem_idx; obs_mem_wdata = o_mem_wdata;
    obs_f_rvalid = o_f_rvalid; obs_f_rdata = o_f_rdata; obs_f_err = o_f_err;
    obs_l_rvalid = o_l_rvalid; obs_l_rdata = o_l_rdata; obs_l_err = o_l_err;
    obs_stat_f = o_stat_f_stall; obs_stat_l = o_stat_l_grant;
    if (!i_reset && fv && !o_f_ready) n_stall++;
    if (!i_reset && o_l_ready) n_lgnt++;
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    i_f_valid = 1'b1; i_l_valid = 1'b1; i_l_we = 1'b1; i_l_addr = 32'h4; i_l_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 16; i++) begin
      bd_we = 1'b1; bd_idx = 11'(i); bd_data = (i == 0) ? 32'hDEAD_BEEF : 32'hA000_0000 + 32'(i);
      exp_mem[i] = bd_data;
      @(posedge i_clk); #1;
    end
    bd_we = 1'b0;
    @(negedge i_clk);
    n_cmp++; if (o_f_ready !== 1'b0 || o_l_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got f=%b l=%b exp 0", o_f_ready, o_l_ready); end
    n_cmp++; if (o_mem_en !== 1'b0 || o_mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_strobe: got en=%b we=%b exp 0", o_mem_en, o_mem_we); end
    n_cmp++; if (o_mem_idx !== 11'd0 || o_mem_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_mem_bus: got idx=%h wd=%h exp 0", o_mem_idx, o_mem_wdata); end
    n_cmp++; if ({o_f_rvalid, o_f_err, o_f_rdata} !== 34'd0) begin n_fail++; $display("FAIL reset_f_rsp: got v=%b e=%b d=%h exp 0", o_f_rvalid, o_f_err, o_f_rdata); end
    n_cmp++; if ({o_l_rvalid, o_l_err, o_l_rdata} !== 34'd0) begin n_fail++; $display("FAIL reset_l_rsp: got v=%b e=%b d=%h exp 0", o_l_rvalid, o_l_err, o_l_rdata); end
    n_cmp++; if ({o_stat_f_stall, o_stat_l_grant} !== 32'd0) begin n_fail++; $display("FAIL reset_stats: got %h %h exp 0", o_stat_f_stall, o_stat_l_grant); end
    i_f_valid = 1'b0; i_l_valid = 1'b0; i_l_we = 1'b0;
    @(posedge i_clk); #1;
    i_reset = 1'b0; n_stall = 0; n_lgnt = 0;
  endtask

  task automatic test_fetch_basic();
    step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++; if (obs_f_ready !== 1'b1 || obs_mem_en !== 1'b1) begin n_fail++; $display("FAIL fetch0_accept: got ready=%b en=%b exp 1 1", obs_f_ready, obs_mem_en); end
    n_cmp++; if (obs_mem_idx !== 11'd0 || obs_mem_we !== 1'b0) begin n_fail++; $display("FAIL fetch0_bus: got idx=%h we=%b exp 0 0", obs_mem_idx, obs_mem_we); end
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++; if (obs_f_rvalid !== 1'b1 || obs_f_err !== 1'b0) begin n_fail++; $display("FAIL fetch0_rsp: got v=%b e=%b exp 1 0", obs_f_rvalid, obs_f_err); end
    n_cmp++; if (obs_f_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL fetch0_data: got %h exp deadbeef", obs_f_rdata); end
    n_cmp++; if (obs_l_rvalid !== 1'b0) begin n_fail++; $display("FAIL fetch0_lquiet: got l_rvalid=%b exp 0", obs_l_rvalid); end
  endtask

  task automatic test_write_then_read();
    logic [31:0] rd; logic er;
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'h1234_5678);
    model_access(1'b1, 1'b1, 32'h10, 32'h1234_5678, rd, er);
    n_cmp++; if (obs_l_ready !== 1'b1 || obs_mem_we !== 1'b1) begin n_fail++; $display("FAIL wr_accept: got ready=%b we=%b exp 1 1", obs_l_ready, obs_mem_we); end
    n_cmp++; if (obs_mem_idx !== 11'd4 || obs_mem_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_bus: got idx=%h wd=%h exp 4 12345678", obs_mem_idx, obs_mem_wdata); end
    step(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++; if ({obs_l_rvalid, obs_l_err, obs_l_rdata} !== {1'b1, er, rd}) begin n_fail++; $display("FAIL wr_rsp: got v=%b e=%b d=%h exp 1 %b %h", obs_l_rvalid, obs_l_err, obs_l_rdata, er, rd); end
    n_cmp++; if (obs_f_ready !== 1'b1) begin n_fail++; $display("FAIL rd_after_wr_accept: got %b exp 1", obs_f_ready); end
    model_access(1'b0, 1'b0, 32'h10, 32'h0, rd, er);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++; if (obs_f_rvalid !== 1'b1 || obs_f_rdata !== 32'h1234_5678 || rd !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_after_wr_data: got v=%b d=%h exp 1 12345678", obs_f_rvalid, obs_f_rdata); end
  endtask

  task automatic test_errors();
    step(1'b1, 32'h2002, 1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++; if (obs_f_ready !== 1'b1 || obs_mem_en !== 1'b0) begin n_fail++; $display("FAIL misalign_accept: got ready=%b en=%b exp 1 0", obs_f_ready, obs_mem_en); end
    n_cmp++; if (obs_mem_idx !== 11'd4) begin n_fail++; $display("FAIL idx_hold: got %h exp 4", obs_mem_idx); end
    step(1'b1, 32'h2000, 1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++; if ({obs_f_rvalid, obs_f_err, obs_f_rdata} !== {2'b11, 32'h0}) begin n_fail++; $display("FAIL misalign_rsp: got v=%b e=%b d=%h exp 1 1 0", obs_f_rvalid, obs_f_err, obs_f_rdata); end
    n_cmp++; if (obs_mem_en !== 1'b0) begin n_fail++; $display("FAIL oor_f_en: got %b exp 0", obs_mem_en); end
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h4000, 32'hCAFE_F00D);
    n_cmp++; if ({obs_f_rvalid, obs_f_err, obs_f_rdata} !== {2'b10, NOP}) begin n_fail++; $display("FAIL oor_f_rsp: got v=%b e=%b d=%h exp 1 0 13", obs_f_rvalid, obs_f_err, obs_f_rdata); end
    n_cmp++; if (obs_l_ready !== 1'b1 || obs_mem_we !== 1'b0 || obs_mem_en !== 1'b0) begin n_fail++; $display("FAIL oor_l_write: got ready=%b we=%b en=%b exp 1 0 0", obs_l_ready, obs_mem_we, obs_mem_en); end
    step(1'b1, 32'h4001, 1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++; if ({obs_l_rvalid, obs_l_err, obs_l_rdata} !== {2'b11, 32'h0}) begin n_fail++; $display("FAIL oor_l_rsp: got v=%b e=%b d=%h exp 1 1 0", obs_l_rvalid, obs_l_err, obs_l_rdata); end
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++; if ({obs_f_rvalid, obs_f_err, obs_f_rdata} !== {2'b11, 32'h0}) begin n_fail++; $display("FAIL misalign_precedence: got v=%b e=%b d=%h exp 1 1 0", obs_f_rvalid, obs_f_err, obs_f_rdata); end
  endtask

  task automatic test_priority();
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h8, 1'b1, 1'b0, 32'hC, 32'h0);
      n_cmp++; if (obs_l_ready !== (i % 5 != 4) || obs_f_ready !== (i % 5 == 4)) begin n_fail++; $display("FAIL priority_c%0d: got l=%b f=%b exp l=%b", i, obs_l_ready, obs_f_ready, i % 5 != 4); end
    end
  endtask

  task automatic test_random();
    logic fv = 1'b0, lv = 1'b0, lwe = 1'b0, fh = 1'b0, lh = 1'b0, pf, pl, xwe;
    logic [31:0] fa = '0, la = '0, ld = '0, fd = '0, cd = '0;
    logic ef_v = 1'b0, el_v = 1'b0, fe = 1'b0, ce = 1'b0;
    int streak = 0;
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int n = 0; n < 400; n++) begin
      if (!fh) begin fv = $urandom_range(0, 3) != 0; fa = rand_addr(); end
      if (!lh) begin lv = $urandom_range(0, 3) != 0; lwe = 1'($urandom_range(0, 1)); la = rand_addr(); ld = $urandom; end
      pl = lv && !(fv && streak == MAXW);
      pf = fv && !pl;
      xwe = pl && lwe && la % 4 == 0 && la < 32'd8192;
      step(fv, fa, lv, lwe, la, ld);
      n_cmp++; if (obs_l_ready !== pl || obs_f_ready !== pf) begin n_fail++; $display("FAIL rnd_grant_%0d: got l=%b f=%b exp l=%b f=%b", n, obs_l_ready, obs_f_ready, pl, pf); end
      n_cmp++; if (obs_mem_we !== xwe) begin n_fail++; $display("FAIL rnd_we_%0d: got %b exp %b", n, obs_mem_we, xwe); end
      n_cmp++; if (obs_f_rvalid !== ef_v || obs_l_rvalid !== el_v) begin n_fail++; $display("FAIL rnd_rvalid_%0d: got f=%b l=%b exp f=%b l=%b", n, obs_f_rvalid, obs_l_rvalid, ef_v, el_v); end
      if (ef_v) begin n_cmp++; if (obs_f_rdata !== fd || obs_f_err !== fe) begin n_fail++; $display("FAIL rnd_f_rsp_%0d: got d=%h e=%b exp d=%h e=%b", n, obs_f_rdata, obs_f_err, fd, fe); end end
      if (el_v) begin n_cmp++; if (obs_l_rdata !== cd || obs_l_err !== ce) begin n_fail++; $display("FAIL rnd_l_rsp_%0d: got d=%h e=%b exp d=%h e=%b", n, obs_l_rdata, obs_l_err, cd, ce); end end
      ef_v = pf; el_v = pl;
      if (pf) model_access(1'b0, 1'b0, fa, 32'h0, fd, fe);
      if (pl) model_access(1'b1, lwe, la, ld, cd, ce);
      streak = (fv && pl) ? ((streak < MAXW) ? streak + 1 : MAXW) : 0;
      fh = fv && !pf; lh = lv && !pl;
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset_mid_access();
    i_l_valid = 1'b1; i_l_we = 1'b0; i_l_addr = 32'h8;
    @(negedge i_clk);
    n_cmp++; if (o_l_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_grant: got %b exp 1", o_l_ready); end
    #1 i_reset = 1'b1;
    #1;
    n_cmp++; if (o_l_ready !== 1'b0 || o_mem_en !== 1'b0) begin n_fail++; $display("FAIL midrst_drop: got ready=%b en=%b exp 0 0", o_l_ready, o_mem_en); end
    @(posedge i_clk); #1;
    i_l_valid = 1'b0; i_reset = 1'b0; n_stall = 0; n_lgnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      n_cmp++; if (o_l_rvalid !== 1'b0 || o_f_rvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_norsp_%0d: got l=%b f=%b exp 0 0", i, o_l_rvalid, o_f_rvalid); end
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_stats();
    for (int i = 0; i < 60; i++)
      step($urandom_range(0, 2) != 0, 32'($urandom_range(0, 15) * 4), $urandom_range(0, 2) != 0, 1'b0, 32'($urandom_range(0, 15) * 4), 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
`ifdef IMEM_ARB_STATS_EN
    n_cmp++; if (obs_stat_f !== 16'(n_stall)) begin n_fail++; $display("FAIL stat_f_stall: got %0d exp %0d", obs_stat_f, n_stall); end
    n_cmp++; if (obs_stat_l !== 16'(n_lgnt)) begin n_fail++; $display("FAIL stat_l_grant: got %0d exp %0d", obs_stat_l, n_lgnt); end
`else
    n_cmp++; if (obs_stat_f !== 16'd0 || obs_stat_l !== 16'd0) begin n_fail++; $display("FAIL stat_tied: got %0d %0d exp 0 0 (stalls seen %0d)", obs_stat_f, obs_stat_l, n_stall); end
`endif
  endtask

  initial begin
    #1;
    test_reset();
    test_fetch_basic();
    test_write_then_read();
    test_errors();
    test_priority();
    test_random();
    test_reset_mid_access();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
